ngmux_switch_ctrl: RTL

Controller that sequences source changes on the glitchless NGMUX clock mux (CLK0/CLK1, SEL). It takes switch requests from the system/config logic and checks that the target source's PLL lock is valid. It holds the downstream clock-domain reset across the switch, drives SEL, waits for the mux to settle, then releases reset and reports completion. It runs on an always-on reference clock, independent of either muxed clock.

---
 rtl/ngmux_ctrl_pkg.sv | 24 ++
 rtl/ngmux_lock_sync.sv | 23 ++
 rtl/ngmux_switch_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ngmux_ctrl_pkg.sv
// rtl/ngmux_ctrl_pkg.sv - shared types and helpers for the NGMUX switch controller
package ngmux_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_QUIESCE = 3'd2,
        ST_CHECK   = 3'd3,
        ST_SETTLE  = 3'd4
    } state_t;

    localparam logic SRC_CLK0 = 1'b0;
    localparam logic SRC_CLK1 = 1'b1;

    // One down-counter serves all three timed phases, so it is sized for the longest
    function automatic int cnt_width(input int q, input int s, input int l);
        int m;
        m = q;
        if (s > m) m = s;
        if (l > m) m = l;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ngmux_lock_sync.sv
// rtl/ngmux_lock_sync.sv - multi-stage synchroniser for the two asynchronous PLL lock inputs
module ngmux_lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [1:0] i_lock,
    output logic [1:0] o_lock
);

    logic [SYNC_STAGES-1:0][1:0] r_sync;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_lock};
        end
    end

    assign o_lock = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ngmux_switch_ctrl.sv
// rtl/ngmux_switch_ctrl.sv - sequences NGMUX source changes with downstream reset and lock checks
// Optional automatic failover on current-source lock loss: NGMUX_CTRL_FAILOVER_EN
module ngmux_switch_ctrl
    import ngmux_ctrl_pkg::*;
#(
    parameter logic DEFAULT_SEL    = SRC_CLK0,
    parameter int   QUIESCE_CYCLES = 16,
    parameter int   SETTLE_CYCLES  = 32,
    parameter int   LOCK_TIMEOUT   = 1024,
    parameter int   SYNC_STAGES    = 2
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic REQ_VALID,
    input  logic REQ_SEL,
    output logic REQ_READY,
    input  logic LOCK0,
    input  logic LOCK1,
    output logic SEL,
    output logic CLKOUT_RESETN,
    output logic BUSY,
    output logic DONE,
    output logic ERR,
`ifdef NGMUX_CTRL_FAILOVER_EN
    output logic FAILOVER,
`endif
    output logic CUR_SEL
);

    localparam int CW = cnt_width(QUIESCE_CYCLES, SETTLE_CYCLES, LOCK_TIMEOUT);
    localparam logic [CW-1:0] C_QUIESCE = CW'(QUIESCE_CYCLES - 1);
    localparam logic [CW-1:0] C_SETTLE  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] C_TIMEOUT = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] C_ONE     = CW'(1);

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_tgt, w_tgt_nxt;
    logic            r_sel, w_sel_nxt;
    logic            r_cur_sel, w_cur_nxt;
    logic            r_rstn, w_rstn_nxt;
    logic            r_done, w_done_nxt;
    logic            r_err, w_err_nxt;

    logic [1:0]      w_lock;
    logic            w_lock_cur;
    logic            w_lock_tgt;
    logic            w_lock_loss;
    logic            w_accept;
    logic            w_cnt_zero;
    logic            w_fo_go;

    ngmux_lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .CLK    (CLK),
        .RESETN (RESETN),
        .i_lock ({LOCK1, LOCK0}),
        .o_lock (w_lock)
    );

    assign w_lock_cur  = w_lock[r_cur_sel];
    assign w_lock_tgt  = w_lock[r_tgt];
    assign w_lock_loss = (r_state == ST_IDLE) && !w_lock_cur;
    assign w_cnt_zero  = (r_cnt == '0);
    // Not ready while lock is lost so a request never races the lock-loss exit
    assign REQ_READY   = (r_state == ST_IDLE) && w_lock_cur;
    assign w_accept    = REQ_VALID && REQ_READY;

`ifdef NGMUX_CTRL_FAILOVER_EN
    logic r_auto;
    logic r_failover;

    assign w_fo_go = w_lock_loss && w_lock[~r_cur_sel];

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_auto     <= 1'b0;
            r_failover <= 1'b0;
        end else begin
            if (w_fo_go) begin
                r_auto <= 1'b1;
            end else if (w_accept) begin
                r_auto <= 1'b0;
            end
            r_failover <= (r_state == ST_SETTLE) && w_cnt_zero && r_auto;
        end
    end

    assign FAILOVER = r_failover;
`else
    assign w_fo_go = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state   <= ST_INIT;
            r_cnt     <= '0;
            r_tgt     <= DEFAULT_SEL;
            r_sel     <= DEFAULT_SEL;
            r_cur_sel <= DEFAULT_SEL;
            r_rstn    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tgt     <= w_tgt_nxt;
            r_sel     <= w_sel_nxt;
            r_cur_sel <= w_cur_nxt;
            r_rstn    <= w_rstn_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:    if (w_lock_cur) w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (w_fo_go)                                 w_state_nxt = ST_QUIESCE;
                else if (w_lock_loss)                        w_state_nxt = ST_INIT;
                else if (w_accept && (REQ_SEL != r_cur_sel)) w_state_nxt = ST_QUIESCE;
            end
            ST_QUIESCE: if (w_cnt_zero) w_state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (w_lock_tgt)      w_state_nxt = ST_SETTLE;
                else if (w_cnt_zero) w_state_nxt = ST_INIT;
            end
            ST_SETTLE:  if (w_cnt_zero) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_tgt_nxt  = r_tgt;
        w_sel_nxt  = r_sel;
        w_cur_nxt  = r_cur_sel;
        w_rstn_nxt = r_rstn;
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (w_lock_cur) w_rstn_nxt = 1'b1;
            end
            ST_IDLE: begin
                if (w_fo_go) begin
                    w_tgt_nxt  = ~r_cur_sel;
                    w_rstn_nxt = 1'b0;
                    w_cnt_nxt  = C_QUIESCE;
                end else if (w_lock_loss) begin
                    w_rstn_nxt = 1'b0;
                end else if (w_accept) begin
                    if (REQ_SEL == r_cur_sel) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_tgt_nxt  = REQ_SEL;
                        w_rstn_nxt = 1'b0;
                        w_cnt_nxt  = C_QUIESCE;
                    end
                end
            end
            ST_QUIESCE: begin
                w_cnt_nxt = w_cnt_zero ? C_TIMEOUT : (r_cnt - C_ONE);
            end
            ST_CHECK: begin
                if (w_lock_tgt) begin
                    w_sel_nxt = r_tgt;
                    w_cnt_nxt = C_SETTLE;
                end else if (w_cnt_zero) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            ST_SETTLE: begin
                // Target lock is deliberately not re-checked here; the mux has already switched
                if (w_cnt_zero) begin
                    w_cur_nxt  = r_sel;
                    w_rstn_nxt = 1'b1;
                    w_done_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
    end

    assign SEL           = r_sel;
    assign CUR_SEL       = r_cur_sel;
    assign CLKOUT_RESETN = r_rstn;
    assign BUSY          = (r_state != ST_IDLE);
    assign DONE          = r_done;
    assign ERR           = r_err;

endmodule
